// File: rtl/arb_mux_reg.sv
// Registered N-channel arbiter/mux with valid/ready handshakes.
// Fixed-priority or round-robin grant, a forced-select override, and one output register stage.
module arb_mux_reg #(
  parameter int N        = 32,
  parameter int CHANNELS = 4,
  parameter int SELW     = 2,
  parameter int MODE     = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [CHANNELS*N-1:0] InData,
  input  logic [CHANNELS-1:0]   InValid,
  output logic [CHANNELS-1:0]   InReady,
  input  logic                  ForceEn,
  input  logic [SELW-1:0]       ForceSelect,
  output logic [N-1:0]          OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [SELW-1:0]       OutSelect
);

  logic [N-1:0]        words [CHANNELS];
  logic [CHANNELS-1:0] cand;
  logic [SELW-1:0]     gnt_idx;
  logic [SELW-1:0]     last_ptr;
  logic                gnt_found;
  logic                free;
  logic                xfer;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_words
    assign words[g] = InData[g*N +: N];
  end

  // A forced select that matches no channel leaves every candidate bit clear
  always_comb begin
    cand = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!ForceEn) begin
        cand[i] = InValid[i];
      end else if (ForceSelect == SELW'(i)) begin
        cand[i] = InValid[i];
      end
    end
  end

  // Scan from lowest to highest priority so the last hit is the winner
  always_comb begin : p_grant
    int              idx;
    logic [SELW-1:0] sel_i;
    idx       = 0;
    sel_i     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    if (MODE == 0) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (cand[i]) begin
          gnt_idx   = SELW'(i);
          gnt_found = 1'b1;
        end
      end
    end else begin
      // i=0 revisits the pointer itself; i=CHANNELS-1 is last+1
      for (int i = 0; i < CHANNELS; i++) begin
        idx   = (int'(last_ptr) + CHANNELS - i) % CHANNELS;
        sel_i = SELW'(idx);
        if (cand[sel_i]) begin
          gnt_idx   = sel_i;
          gnt_found = 1'b1;
        end
      end
    end
  end

  assign free = ~OutValid | OutReady;
  assign xfer = ~Reset & free & gnt_found;

  always_comb begin
    InReady = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      InReady[i] = xfer & (gnt_idx == SELW'(i));
    end
  end

  // Output register: load on transfer, drop valid on a drain with nothing new
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      OutData   <= '0;
      OutValid  <= 1'b0;
      OutSelect <= '0;
      last_ptr  <= SELW'(CHANNELS - 1);
    end else if (xfer) begin
      OutData   <= words[gnt_idx];
      OutValid  <= 1'b1;
      OutSelect <= gnt_idx;
      if (MODE != 0) begin
        last_ptr <= gnt_idx;
      end
    end else if (OutReady) begin
      OutValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: round-robin, fixed-priority and 3-channel instances share one stimulus;
// a vector table covers steady-state arbitration, hand sequences cover stall, range and reset cases.
module tb_arb_mux_reg;

  logic         Clock = 1'b0;
  logic         Reset;
  logic [31:0]  chan_data [4];
  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic         force_en;
  logic [1:0]   force_sel;
  logic         out_ready;

  logic [3:0]  rr_rdy, fp_rdy;
  logic [2:0]  c3_rdy;
  logic [31:0] rr_data, fp_data, c3_data;
  logic        rr_ov, fp_ov, c3_ov;
  logic [1:0]  rr_sel, fp_sel, c3_sel;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  always_comb begin
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = chan_data[i];
  end

  arb_mux_reg #(.N(32), .CHANNELS(4), .SELW(2), .MODE(1)) dut_rr (
    .Clock(Clock), .Reset(Reset), .InData(in_data), .InValid(in_valid), .InReady(rr_rdy),
    .ForceEn(force_en), .ForceSelect(force_sel), .OutData(rr_data), .OutValid(rr_ov),
    .OutReady(out_ready), .OutSelect(rr_sel));

  arb_mux_reg #(.N(32), .CHANNELS(4), .SELW(2), .MODE(0)) dut_fp (
    .Clock(Clock), .Reset(Reset), .InData(in_data), .InValid(in_valid), .InReady(fp_rdy),
    .ForceEn(force_en), .ForceSelect(force_sel), .OutData(fp_data), .OutValid(fp_ov),
    .OutReady(out_ready), .OutSelect(fp_sel));

  arb_mux_reg #(.N(32), .CHANNELS(3), .SELW(2), .MODE(0)) dut_c3 (
    .Clock(Clock), .Reset(Reset), .InData(in_data[95:0]), .InValid(in_valid[2:0]), .InReady(c3_rdy),
    .ForceEn(force_en), .ForceSelect(force_sel), .OutData(c3_data), .OutValid(c3_ov),
    .OutReady(out_ready), .OutSelect(c3_sel));

  typedef struct {
    logic [3:0] inval;
    logic       ordy;
    logic       fen;
    logic [1:0] fsel;
    logic [3:0] rr_rdy;
    logic       rr_ov;
    logic [1:0] rr_sel;
    logic [3:0] fp_rdy;
    logic       fp_ov;
    logic [1:0] fp_sel;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    // Round-robin from pointer 3, fixed priority lowest-first, forced select, pointer re-grant
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 4'b0001, 1'b1, 2'd0};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 4'b0001, 1'b1, 2'd0};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 2'd0};
    tbl[5]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 4'b0001, 1'b1, 2'd0};
    tbl[6]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 4'b0001, 1'b1, 2'd0};
    tbl[7]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 4'b0001, 1'b1, 2'd0};
    tbl[8]  = '{4'b1010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 2'd1};
    tbl[9]  = '{4'b1010, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd3, 4'b0010, 1'b1, 2'd1};
    tbl[10] = '{4'b1010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 2'd1};
    tbl[11] = '{4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1, 2'd3, 4'b1000, 1'b1, 2'd3};
    tbl[12] = '{4'b0111, 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0, 2'd3, 4'b0000, 1'b0, 2'd3};
    tbl[13] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 2'd2};
    tbl[14] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 2'd2};
    tbl[15] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 2'd2};
    tbl[16] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 2'd2};
    tbl[17] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 2'd2};

    for (int i = 0; i < 4; i++) chan_data[i] = 32'h1000_0000 * (i + 1) + 32'h0000_00A5;
    Reset = 1'b1; in_valid = '0; force_en = 1'b0; force_sel = '0; out_ready = 1'b0;

    #1;
    check("rst_ov", {31'd0, rr_ov}, 32'd0);
    check("rst_data", rr_data, 32'd0);
    check("rst_sel", {30'd0, rr_sel}, 32'd0);
    check("rst_rdy", {28'd0, rr_rdy}, 32'd0);
    tick();
    tick();
    Reset = 1'b0;

    for (int v = 0; v < 18; v++) begin
      in_valid = tbl[v].inval; out_ready = tbl[v].ordy;
      force_en = tbl[v].fen; force_sel = tbl[v].fsel;
      #1;
      check($sformatf("v%0d_rr_rdy", v), {28'd0, rr_rdy}, {28'd0, tbl[v].rr_rdy});
      check($sformatf("v%0d_fp_rdy", v), {28'd0, fp_rdy}, {28'd0, tbl[v].fp_rdy});
      tick();
      check($sformatf("v%0d_rr_ov", v), {31'd0, rr_ov}, {31'd0, tbl[v].rr_ov});
      check($sformatf("v%0d_rr_sel", v), {30'd0, rr_sel}, {30'd0, tbl[v].rr_sel});
      check($sformatf("v%0d_fp_ov", v), {31'd0, fp_ov}, {31'd0, tbl[v].fp_ov});
      check($sformatf("v%0d_fp_sel", v), {30'd0, fp_sel}, {30'd0, tbl[v].fp_sel});
      if (tbl[v].rr_ov) check($sformatf("v%0d_rr_data", v), rr_data, chan_data[tbl[v].rr_sel]);
      if (tbl[v].fp_ov) check($sformatf("v%0d_fp_data", v), fp_data, chan_data[tbl[v].fp_sel]);
    end

    // Backpressure: ch2 word held while consumer stalls, then ch1 loads on the drain cycle
    chan_data[2] = 32'hDEAD_BEEF; chan_data[1] = 32'hCAFE_0001;
    in_valid = 4'b0100; out_ready = 1'b0; force_en = 1'b0;
    #1 check("bp_load_rdy", {28'd0, rr_rdy}, 32'b0100);
    tick();
    check("bp_load_data", rr_data, 32'hDEAD_BEEF);
    check("bp_load_ov", {31'd0, rr_ov}, 32'd1);
    in_valid = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin force_en = 1'b1; force_sel = 2'd1; end
      #1 check($sformatf("bp_stall%0d_rdy", c), {28'd0, rr_rdy}, 32'd0);
      tick();
      check($sformatf("bp_stall%0d_data", c), rr_data, 32'hDEAD_BEEF);
      check($sformatf("bp_stall%0d_ov", c), {31'd0, rr_ov}, 32'd1);
      check($sformatf("bp_stall%0d_sel", c), {30'd0, rr_sel}, 32'd2);
    end
    out_ready = 1'b1;
    #1 check("bp_drain_rdy", {28'd0, rr_rdy}, 32'b0010);
    tick();
    check("bp_drain_data", rr_data, 32'hCAFE_0001);
    check("bp_drain_sel", {30'd0, rr_sel}, 32'd1);
    check("bp_drain_ov", {31'd0, rr_ov}, 32'd1);

    // Forced select beyond a 3-channel instance grants nothing
    force_en = 1'b1; force_sel = 2'd3; in_valid = 4'b0111; out_ready = 1'b1;
    #1 check("c3_oor_rdy", {29'd0, c3_rdy}, 32'd0);
    tick();
    check("c3_oor_ov", {31'd0, c3_ov}, 32'd0);
    force_sel = 2'd2;
    #1 check("c3_f2_rdy", {29'd0, c3_rdy}, 32'b100);
    tick();
    check("c3_f2_ov", {31'd0, c3_ov}, 32'd1);
    check("c3_f2_sel", {30'd0, c3_sel}, 32'd2);
    check("c3_f2_data", c3_data, 32'hDEAD_BEEF);
    check("rr_f2_ov", {31'd0, rr_ov}, 32'd1);

    // Asynchronous reset while a word is held
    force_en = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    Reset = 1'b1;
    #1;
    check("arst_ov", {31'd0, rr_ov}, 32'd0);
    check("arst_data", rr_data, 32'd0);
    check("arst_sel", {30'd0, rr_sel}, 32'd0);
    check("arst_rr_rdy", {28'd0, rr_rdy}, 32'd0);
    check("arst_fp_rdy", {28'd0, fp_rdy}, 32'd0);
    tick();
    check("arst_hold_ov", {31'd0, rr_ov}, 32'd0);
    Reset = 1'b0;
    #1 check("post_rst_rdy", {28'd0, rr_rdy}, 32'b0001);
    tick();
    check("post_rst_sel", {30'd0, rr_sel}, 32'd0);
    check("post_rst_ov", {31'd0, rr_ov}, 32'd1);
    check("post_rst_data", rr_data, chan_data[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
